// File: rtl/serial_add_unit_if.sv
// Operand/result bundle for the bit-serial adder.
// The master issues start with operands a/b.
// The slave reports busy, the one-cycle done pulse, and the held result s/c.
interface serial_add_unit_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             c;

   modport master (
      output start, a, b,
      input  busy, done, s, c
   );

   modport slave (
      input  start, a, b,
      output busy, done, s, c
   );
endinterface

// File: rtl/serial_add_unit.sv
// Bit-serial ripple adder. It processes one operand bit per clock, LSB first.
// IDLE accepts start and captures the operands.
// RUN spends WIDTH cycles on the bits.
// DONE pulses done for one cycle and always falls back to IDLE.
// s/c are only written on the final RUN edge, so they hold the last completed result.
module serial_add_unit #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   serial_add_unit_if.slave  bus
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_sh_reg, b_sh_reg, part_reg, s_reg;
   logic             cy_reg, c_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             busy_int, done_int;

   // Bit datapath: two cascaded half adders, with their carries ORed.
   logic ha1_sum, ha1_cry, ha2_sum, ha2_cry, bit_cry, last_bit;
   assign ha1_sum  = a_sh_reg[0] ^ b_sh_reg[0];
   assign ha1_cry  = a_sh_reg[0] & b_sh_reg[0];
   assign ha2_sum  = ha1_sum ^ cy_reg;
   assign ha2_cry  = ha1_sum & cy_reg;
   assign bit_cry  = ha1_cry | ha2_cry;
   assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

   // State register; reset wins over everything, which also aborts a running addition.
   always_ff @(posedge clk) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Next-state logic; busy and done decode directly from the registered state.
   always_comb begin
      state_next = state_reg;
      busy_int   = 1'b0;
      done_int   = 1'b0;
      case (state_reg)
         IDLE: if (bus.start) state_next = RUN;
         RUN: begin
            busy_int = 1'b1;
            if (last_bit) state_next = DONE;
         end
         DONE: begin
            done_int   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand shift registers, carry, counter, partial result and held result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sh_reg <= '0;
         b_sh_reg <= '0;
         part_reg <= '0;
         s_reg    <= '0;
         cy_reg   <= 1'b0;
         c_reg    <= 1'b0;
         cnt_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  a_sh_reg <= bus.a;
                  b_sh_reg <= bus.b;
                  part_reg <= '0;
                  cy_reg   <= 1'b0;
                  cnt_reg  <= '0;
               end
            end
            RUN: begin
               a_sh_reg <= a_sh_reg >> 1;
               b_sh_reg <= b_sh_reg >> 1;
               part_reg <= {ha2_sum, part_reg[WIDTH-1:1]};
               cy_reg   <= bit_cry;
               cnt_reg  <= cnt_reg + CNT_W'(1);
               // The final sum bit is still in flight, so splice it in directly.
               if (last_bit) begin
                  s_reg <= {ha2_sum, part_reg[WIDTH-1:1]};
                  c_reg <= bit_cry;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = busy_int;
   assign bus.done = done_int;
   assign bus.s    = s_reg;
   assign bus.c    = c_reg;

endmodule

// File: tb/tb_serial_add_unit.sv
// Bench for serial_add_unit (WIDTH=8).
// Expected sums come from plain integer addition.
// Expected timing comes from the documented latency of WIDTH edges and period of WIDTH+2.
module tb_serial_add_unit;

   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   serial_add_unit_if #(.WIDTH(WIDTH)) bus ();

   serial_add_unit #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: the WIDTH+1 bit sum, where the top bit is the carry.
   function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      return {1'b0, x} + {1'b0, y};
   endfunction

   // Drive one addition and report what was observed.
   // The operands are scrambled right after the accepting edge.
   task automatic do_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         output int lat, output int busy_cnt,
                         output logic [WIDTH-1:0] so, output logic co,
                         output bit stable, output bit timeout);
      logic [WIDTH-1:0] s0;
      logic             c0;
      @(negedge clk);
      bus.a = x; bus.b = y; bus.start = 1'b1;
      s0 = bus.s; c0 = bus.c;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      bus.a = WIDTH'($urandom);
      bus.b = WIDTH'($urandom);
      lat = -1; busy_cnt = 0; stable = 1'b1; timeout = 1'b1;
      so = bus.s; co = bus.c;
      for (int k = 0; k < 4 * WIDTH; k++) begin
         if (k > 0) @(negedge clk);
         if (bus.done) begin
            lat = k; so = bus.s; co = bus.c; timeout = 1'b0;
            break;
         end
         if (bus.busy) busy_cnt++;
         if (bus.s !== s0 || bus.c !== c0) stable = 1'b0;
      end
      $display("add a=%02h b=%02h -> s=%02h c=%0b lat=%0d busy=%0d", x, y, so, co, lat, busy_cnt);
   endtask

   task automatic test_reset;
      bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      n_cmp++; if (bus.s !== 8'h00) begin n_bad++; $display("FAIL reset_s got=%02h exp=00", bus.s); end
      n_cmp++; if (bus.c !== 1'b0) begin n_bad++; $display("FAIL reset_c got=%b exp=0", bus.c); end
      bus.start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed;
      logic [WIDTH-1:0] va [5] = '{8'h00, 8'hFF, 8'hA5, 8'h80, 8'h10};
      logic [WIDTH-1:0] vb [5] = '{8'h00, 8'h01, 8'h5A, 8'h80, 8'h20};
      int lat, bc;
      logic [WIDTH-1:0] so;
      logic co;
      bit st, to;
      logic [WIDTH:0] e;
      for (int i = 0; i < 5; i++) begin
         do_add(va[i], vb[i], lat, bc, so, co, st, to);
         e = ref_sum(va[i], vb[i]);
         n_cmp++; if (to || so !== e[WIDTH-1:0]) begin n_bad++; $display("FAIL dir_s[%0d] got=%02h exp=%02h", i, so, e[WIDTH-1:0]); end
         n_cmp++; if (to || co !== e[WIDTH]) begin n_bad++; $display("FAIL dir_c[%0d] got=%b exp=%b", i, co, e[WIDTH]); end
         n_cmp++; if (lat != WIDTH) begin n_bad++; $display("FAIL dir_latency[%0d] got=%0d exp=%0d", i, lat, WIDTH); end
         n_cmp++; if (bc != WIDTH) begin n_bad++; $display("FAIL dir_busy_cycles[%0d] got=%0d exp=%0d", i, bc, WIDTH); end
         n_cmp++; if (!st) begin n_bad++; $display("FAIL dir_hold_during_run[%0d] got=changed exp=stable", i); end
      end
   endtask

   task automatic test_random;
      int lat, bc;
      logic [WIDTH-1:0] x, y, so;
      logic co;
      bit st, to;
      logic [WIDTH:0] e;
      for (int i = 0; i < 20; i++) begin
         x = WIDTH'($urandom);
         y = WIDTH'($urandom);
         do_add(x, y, lat, bc, so, co, st, to);
         e = ref_sum(x, y);
         n_cmp++; if (to || {co, so} !== e) begin n_bad++; $display("FAIL rnd_sum[%0d] got=%b_%02h exp=%b_%02h", i, co, so, e[WIDTH], e[WIDTH-1:0]); end
         n_cmp++; if (lat != WIDTH || bc != WIDTH) begin n_bad++; $display("FAIL rnd_timing[%0d] got lat=%0d busy=%0d exp=%0d", i, lat, bc, WIDTH); end
         @(negedge clk);
         n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL rnd_done_width[%0d] got done=%b busy=%b exp=0/0", i, bus.done, bus.busy); end
      end
   endtask

   task automatic test_ignore_start;
      int dones = 0;
      logic [WIDTH-1:0] so = '0;
      logic co = 1'b1;
      @(negedge clk);
      bus.a = 8'h10; bus.b = 8'h20; bus.start = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 3 * WIDTH; k++) begin
         @(negedge clk);
         if (bus.done) begin dones++; so = bus.s; co = bus.c; end
         // Keep requesting with new operands through RUN and DONE.
         bus.start = (k <= WIDTH);
         bus.a = 8'h01; bus.b = 8'h01;
      end
      $display("ignore_start: dones=%0d s=%02h c=%0b", dones, so, co);
      n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL ign_done_count got=%0d exp=1", dones); end
      n_cmp++; if (so !== 8'h30 || co !== 1'b0) begin n_bad++; $display("FAIL ign_result got=%b_%02h exp=0_30", co, so); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL ign_no_restart busy got=%b exp=0", bus.busy); end
   endtask

   task automatic test_reset_abort;
      int dones = 0, lat, bc;
      logic [WIDTH-1:0] so;
      logic co;
      bit st, to;
      @(negedge clk);
      bus.a = 8'h55; bus.b = 8'h11; bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_bad++; $display("FAIL abort_flags got busy=%b done=%b exp=0/0", bus.busy, bus.done); end
      n_cmp++; if (bus.s !== 8'h00 || bus.c !== 1'b0) begin n_bad++; $display("FAIL abort_result got=%b_%02h exp=0_00", bus.c, bus.s); end
      rst_n = 1'b1;
      for (int k = 0; k < WIDTH + 4; k++) begin
         @(negedge clk);
         if (bus.done || bus.busy) dones++;
      end
      n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL abort_no_done got=%0d active cycles exp=0", dones); end
      do_add(8'h03, 8'h04, lat, bc, so, co, st, to);
      n_cmp++; if (to || so !== 8'h07 || co !== 1'b0 || lat != WIDTH) begin n_bad++; $display("FAIL abort_restart got=%b_%02h lat=%0d exp=0_07 lat=%0d", co, so, lat, WIDTH); end
   endtask

   task automatic test_back_to_back;
      localparam int N = 6;
      logic [WIDTH-1:0] opa [N];
      logic [WIDTH-1:0] opb [N];
      logic [WIDTH-1:0] held_s = '0;
      logic held_c = 1'b0;
      logic [WIDTH:0] e;
      int idx = 0, cyc = 0, last = 0, unstable = 0;
      for (int i = 0; i < N; i++) begin
         opa[i] = WIDTH'($urandom);
         opb[i] = WIDTH'($urandom);
      end
      @(negedge clk);
      bus.a = opa[0]; bus.b = opb[0]; bus.start = 1'b1;
      for (int k = 0; k < N * (WIDTH + 2) + 20 && idx < N; k++) begin
         @(negedge clk);
         cyc++;
         if (bus.done) begin
            e = ref_sum(opa[idx], opb[idx]);
            $display("b2b[%0d] a=%02h b=%02h -> s=%02h c=%0b", idx, opa[idx], opb[idx], bus.s, bus.c);
            n_cmp++; if ({bus.c, bus.s} !== e) begin n_bad++; $display("FAIL b2b_sum[%0d] got=%b_%02h exp=%b_%02h", idx, bus.c, bus.s, e[WIDTH], e[WIDTH-1:0]); end
            if (idx > 0) begin
               n_cmp++; if (cyc - last != WIDTH + 2) begin n_bad++; $display("FAIL b2b_period[%0d] got=%0d exp=%0d", idx, cyc - last, WIDTH + 2); end
            end
            last = cyc; held_s = bus.s; held_c = bus.c;
            idx++;
            if (idx < N) begin bus.a = opa[idx]; bus.b = opb[idx]; end
            else bus.start = 1'b0;
         end else begin
            if (idx > 0 && (bus.s !== held_s || bus.c !== held_c)) unstable++;
            // Scramble the operands while running; they must not leak into the result.
            if (bus.busy) begin bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); end
         end
      end
      bus.start = 1'b0;
      n_cmp++; if (idx != N) begin n_bad++; $display("FAIL b2b_completed got=%0d exp=%0d", idx, N); end
      n_cmp++; if (unstable != 0) begin n_bad++; $display("FAIL b2b_hold got=%0d changes exp=0", unstable); end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
